// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - EX/MEM and MEM/WB pipeline records and the memory-stage FSM states.
package pipeline_types;
    import rv32_isa::*;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] func3;
    } ctrl_t;

    typedef struct packed {
        logic [4:0]          addr;
        logic [RegWidth-1:0] value;
    } rd_t;

    typedef struct packed {
        ctrl_t               ctrl;
        logic [RegWidth-1:0] rs;
        rd_t                 rd;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t ctrl;
        rd_t   rd;
    } mem_wb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/rv32_isa.sv
// rtl/rv32_isa.sv - RV32I register width and load/store func3 encodings.
package rv32_isa;

    localparam int unsigned RegWidth = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - Store lane replication/byte enables, alignment check and load extraction.
module mem_align
    import rv32_isa::*;
(
    input  logic [1:0]  stSize,
    input  logic [1:0]  stAddr,
    input  logic [31:0] rs,
    output logic [31:0] wData,
    output logic [3:0]  be,
    output logic        misalign,
    input  logic [2:0]  ldFunc3,
    input  logic [1:0]  ldAddr,
    input  logic [31:0] rData,
    output logic [31:0] ldData
);

    logic [31:0] shifted;

    always_comb begin
        wData    = rs;
        be       = 4'b1111;
        misalign = 1'b0;
        case (stSize)
            2'b00: begin
                wData = {4{rs[7:0]}};
                be    = 4'b0001 << stAddr;
            end
            2'b01: begin
                wData    = {2{rs[15:0]}};
                be       = 4'b0011 << {stAddr[1], 1'b0};
                misalign = stAddr[0];
            end
            default: begin
                misalign = |stAddr;
            end
        endcase
    end

    always_comb begin
        shifted = rData >> {ldAddr, 3'b000};
        case (ldFunc3)
            F3_LB:   ldData = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ldData = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  ldData = {24'd0, shifted[7:0]};
            F3_LHU:  ldData = {16'd0, shifted[15:0]};
            default: ldData = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Pipeline MEM stage: issues data-bus accesses, waits for ack with timeout, retires to WB.
module mem_stage
    import rv32_isa::*;
    import pipeline_types::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStall,
    input  ex_mem_t             iEX,
    output mem_wb_t             oWB,
    output logic [RegWidth-1:0] oFwMe,
    output logic                oStall,
    output logic                oDReq,
    output logic                oDWe,
    output logic [31:0]         oDAddr,
    output logic [3:0]          oDBe,
    output logic [31:0]         oDWData,
    input  logic                iDAck,
    input  logic [31:0]         iDRData,
    output logic                oErr,
    output logic                oMisalign
);

    localparam int CntW = $clog2(TIMEOUT + 1);

    mem_state_e      state, nextState;
    logic [CntW-1:0] waitCnt;
    ctrl_t           pendCtrl;
    logic [4:0]      pendRd;
    logic [1:0]      pendAddrLo;
    mem_wb_t         doneBuf;

    logic        memOp, issue, misalignHit, ackHit, toHit;
    logic [31:0] wData, ldData;
    logic [3:0]  be;
    logic        misalign;
    mem_wb_t     finRes;

    assign memOp = iEX.ctrl.mem_read | iEX.ctrl.mem_write;
    assign oFwMe = oWB.rd.value;

    mem_align uAlign (
        .stSize   (iEX.ctrl.func3[1:0]),
        .stAddr   (iEX.rd.value[1:0]),
        .rs       (iEX.rs),
        .wData    (wData),
        .be       (be),
        .misalign (misalign),
        .ldFunc3  (pendCtrl.func3),
        .ldAddr   (pendAddrLo),
        .rData    (iDRData),
        .ldData   (ldData)
    );

    // A timed-out access retires as a harmless no-write instruction.
    always_comb begin
        finRes         = '0;
        finRes.ctrl    = pendCtrl;
        finRes.rd.addr = pendRd;
        if (ackHit && pendCtrl.mem_read) begin
            finRes.rd.value = ldData;
        end
        if (!ackHit || pendCtrl.mem_write) begin
            finRes.ctrl.reg_write = 1'b0;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The retiring cycle of BUSY (ack or timeout) releases the stall so EX advances on that edge.
    always_comb begin
        nextState   = state;
        oStall      = 1'b0;
        issue       = 1'b0;
        misalignHit = 1'b0;
        ackHit      = 1'b0;
        toHit       = 1'b0;
        case (state)
            IDLE: begin
                if (!iStall && memOp) begin
                    if (misalign) begin
                        misalignHit = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        oStall    = 1'b1;
                        nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                if (iDAck) begin
                    ackHit    = 1'b1;
                    nextState = iStall ? DONE : IDLE;
                end else if (waitCnt == CntW'(TIMEOUT - 1)) begin
                    toHit     = 1'b1;
                    nextState = iStall ? DONE : IDLE;
                end else begin
                    oStall = 1'b1;
                end
            end
            DONE: begin
                if (!iStall) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oWB        <= '0;
            oDReq      <= 1'b0;
            oDWe       <= 1'b0;
            oDAddr     <= '0;
            oDBe       <= '0;
            oDWData    <= '0;
            oErr       <= 1'b0;
            oMisalign  <= 1'b0;
            waitCnt    <= '0;
            pendCtrl   <= '0;
            pendRd     <= '0;
            pendAddrLo <= '0;
            doneBuf    <= '0;
        end else begin
            oErr      <= toHit;
            oMisalign <= misalignHit;
            case (state)
                IDLE: begin
                    if (!iStall) begin
                        if (issue || misalignHit) begin
                            oWB <= '0;
                        end else begin
                            oWB <= mem_wb_t'{ctrl: iEX.ctrl, rd: iEX.rd};
                        end
                    end
                    if (issue) begin
                        oDReq      <= 1'b1;
                        oDWe       <= iEX.ctrl.mem_write;
                        oDAddr     <= {iEX.rd.value[31:2], 2'b00};
                        oDBe       <= be;
                        oDWData    <= wData;
                        pendCtrl   <= iEX.ctrl;
                        pendRd     <= iEX.rd.addr;
                        pendAddrLo <= iEX.rd.value[1:0];
                        waitCnt    <= '0;
                    end
                end
                BUSY: begin
                    if (ackHit || toHit) begin
                        oDReq <= 1'b0;
                        if (iStall) begin
                            doneBuf <= finRes;
                        end else begin
                            oWB <= finRes;
                        end
                    end else begin
                        waitCnt <= waitCnt + CntW'(1);
                        if (!iStall) begin
                            oWB <= '0;
                        end
                    end
                end
                DONE: begin
                    if (!iStall) begin
                        oWB <= doneBuf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import rv32_isa::*;
    import pipeline_types::*;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iStall;
    ex_mem_t       iEX;
    mem_wb_t       oWB;
    logic [31:0]   oFwMe;
    logic          oStall;
    logic          oDReq;
    logic          oDWe;
    logic [31:0]   oDAddr;
    logic [3:0]    oDBe;
    logic [31:0]   oDWData;
    logic          iDAck;
    logic [31:0]   iDRData;
    logic          oErr;
    logic          oMisalign;

    int passCnt = 0;
    int totalCnt = 0;

    mem_stage #(.TIMEOUT(16)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStall    (iStall),
        .iEX       (iEX),
        .oWB       (oWB),
        .oFwMe     (oFwMe),
        .oStall    (oStall),
        .oDReq     (oDReq),
        .oDWe      (oDWe),
        .oDAddr    (oDAddr),
        .oDBe      (oDBe),
        .oDWData   (oDWData),
        .iDAck     (iDAck),
        .iDRData   (iDRData),
        .oErr      (oErr),
        .oMisalign (oMisalign)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    function automatic ex_mem_t mkEx(input logic rw, input logic mr, input logic mw,
                                     input logic [2:0] f3, input logic [31:0] rs,
                                     input logic [4:0] rdA, input logic [31:0] val);
        ex_mem_t e;
        e.ctrl.reg_write = rw;
        e.ctrl.mem_read  = mr;
        e.ctrl.mem_write = mw;
        e.ctrl.func3     = f3;
        e.rs             = rs;
        e.rd.addr        = rdA;
        e.rd.value       = val;
        return e;
    endfunction

    initial begin
        iRst    = 1'b1;
        iStall  = 1'b0;
        iEX     = '0;
        iDAck   = 1'b0;
        iDRData = '0;
        #12;
        check("rst_wb", 32'(oWB), 32'h0);
        check("rst_dreq", 32'(oDReq), 32'h0);
        check("rst_dbe", 32'(oDBe), 32'h0);
        check("rst_err", 32'(oErr), 32'h0);
        #10 iRst = 1'b0;

        // ALU passthrough, latency 1
        iEX = mkEx(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 5'd5, 32'h1234);
        step();
        check("alu_rd_addr", 32'(oWB.rd.addr), 32'd5);
        check("alu_rd_value", oWB.rd.value, 32'h1234);
        check("alu_fwd", oFwMe, 32'h1234);
        check("alu_dreq", 32'(oDReq), 32'h0);
        iEX = '0;

        // LB 0x103, ack on first BUSY cycle
        iEX = mkEx(1'b1, 1'b1, 1'b0, F3_LB, 32'h0, 5'd6, 32'h103);
        #1;
        check("lb_stall_idle", 32'(oStall), 32'h1);
        step();
        check("lb_dreq", 32'(oDReq), 32'h1);
        check("lb_daddr", oDAddr, 32'h100);
        check("lb_dwe", 32'(oDWe), 32'h0);
        check("lb_bubble", 32'(oWB), 32'h0);
        iDAck = 1'b1;
        iDRData = 32'h80FF_FFFF;
        #1;
        check("lb_stall_ack", 32'(oStall), 32'h0);
        step();
        check("lb_value", oWB.rd.value, 32'hFFFF_FF80);
        check("lb_rd_addr", 32'(oWB.rd.addr), 32'd6);
        check("lb_dreq_drop", 32'(oDReq), 32'h0);
        iDAck = 1'b0;
        iEX = '0;
        #1;
        check("lb_stall_after", 32'(oStall), 32'h0);

        // SH 0x202
        iEX = mkEx(1'b0, 1'b0, 1'b1, F3_SH, 32'hABCD_1234, 5'd0, 32'h202);
        step();
        check("sh_dwe", 32'(oDWe), 32'h1);
        check("sh_dbe", 32'(oDBe), 32'hC);
        check("sh_wdata", oDWData, 32'h1234_1234);
        check("sh_daddr", oDAddr, 32'h200);
        iDAck = 1'b1;
        step();
        check("sh_dreq_drop", 32'(oDReq), 32'h0);
        check("sh_no_regwrite", 32'(oWB.ctrl.reg_write), 32'h0);
        iDAck = 1'b0;
        iEX = '0;

        // SB 0x011
        iEX = mkEx(1'b0, 1'b0, 1'b1, F3_SB, 32'h0000_0055, 5'd0, 32'h011);
        step();
        check("sb_dbe", 32'(oDBe), 32'h2);
        check("sb_wdata", oDWData, 32'h5555_5555);
        iDAck = 1'b1;
        step();
        iDAck = 1'b0;

        // LH 0x002 sign-extended
        iEX = mkEx(1'b1, 1'b1, 1'b0, F3_LH, 32'h0, 5'd10, 32'h002);
        step();
        iDAck = 1'b1;
        iDRData = 32'h8001_7777;
        step();
        check("lh_value", oWB.rd.value, 32'hFFFF_8001);
        iDAck = 1'b0;
        iEX = '0;

        // LW timeout after 16 ack-less BUSY cycles
        iEX = mkEx(1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 5'd7, 32'h040);
        step();
        repeat (15) step();
        check("to_dreq_held", 32'(oDReq), 32'h1);
        check("to_err_early", 32'(oErr), 32'h0);
        step();
        check("to_err_pulse", 32'(oErr), 32'h1);
        check("to_dreq_drop", 32'(oDReq), 32'h0);
        check("to_no_regwrite", 32'(oWB.ctrl.reg_write), 32'h0);
        check("to_value", oWB.rd.value, 32'h0);
        iEX = '0;
        step();
        check("to_err_end", 32'(oErr), 32'h0);

        // Misaligned LW 0x101 behind an ALU op
        iEX = mkEx(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 5'd3, 32'h55);
        step();
        iEX = mkEx(1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 5'd8, 32'h101);
        #1;
        check("mis_stall", 32'(oStall), 32'h0);
        step();
        check("mis_pulse", 32'(oMisalign), 32'h1);
        check("mis_dreq", 32'(oDReq), 32'h0);
        check("mis_bubble", 32'(oWB), 32'h0);
        iEX = '0;
        step();
        check("mis_pulse_end", 32'(oMisalign), 32'h0);

        // LHU with stall on the ack cycle -> DONE
        iEX = mkEx(1'b1, 1'b1, 1'b0, F3_LHU, 32'h0, 5'd9, 32'h302);
        step();
        iStall = 1'b1;
        iDAck = 1'b1;
        iDRData = 32'h8765_4321;
        step();
        iDAck = 1'b0;
        iEX = '0;
        check("lhu_dreq_drop", 32'(oDReq), 32'h0);
        check("lhu_wb_held", 32'(oWB), 32'h0);
        check("lhu_done_stall", 32'(oStall), 32'h0);
        step();
        check("lhu_wb_held2", 32'(oWB), 32'h0);
        iStall = 1'b0;
        step();
        check("lhu_value", oWB.rd.value, 32'h0000_8765);
        check("lhu_rd_addr", 32'(oWB.rd.addr), 32'd9);

        // Reset during BUSY, late ack ignored
        iEX = mkEx(1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 5'd11, 32'h080);
        step();
        check("rb_dreq", 32'(oDReq), 32'h1);
        #2 iRst = 1'b1;
        #1;
        check("rb_async_drop", 32'(oDReq), 32'h0);
        iEX = '0;
        #2 iRst = 1'b0;
        iDAck = 1'b1;
        iDRData = 32'hDEAD_BEEF;
        step();
        check("rb_late_ack_dreq", 32'(oDReq), 32'h0);
        check("rb_late_ack_wb", 32'(oWB), 32'h0);
        iDAck = 1'b0;
        step();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
